// File: rtl/nyancat_frame_sequencer.sv
// Animation frame sequencer for the nyancat renderer.
// The frame index only moves at vertical-blank start, so each displayed field shows a single
// frame. A small command port selects the rate, direction, pause and single-step.
module nyancat_frame_sequencer #(
  parameter int unsigned NUM_FRAMES  = 12,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 6
) (
  input  logic             px_clk,
  input  logic             reset_n,
  input  logic             vblank_start,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DIV_W-1:0] cmd_arg,
  output logic [IDX_W-1:0] frame_index,
  output logic             frame_strobe,
  output logic             playing
);

  typedef enum logic [1:0] {StPlay, StPause, StStep} state_e;

  localparam logic [1:0]       OpSetDiv = 2'd0;
  localparam logic [1:0]       OpPlay   = 2'd1;
  localparam logic [1:0]       OpPause  = 2'd2;
  localparam logic [1:0]       OpStep   = 2'd3;
  localparam logic [DIV_W-1:0] DefDiv   = DIV_W'(DEFAULT_DIV);
  localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(NUM_FRAMES - 1);

  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             strobe_q, strobe_d;

  logic [DIV_W-1:0] div_eff;
  logic             advance;
  logic             cmd_fire;

  // Reset asserts immediately; its release is synchronised to px_clk.
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  assign cmd_ready = (state_q != StStep);
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Next state: vblank is evaluated on the current state, then an accepted command overrides.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    dir_d    = dir_q;
    tick_d   = tick_q;
    idx_d    = idx_q;
    strobe_d = 1'b0;
    advance  = 1'b0;
    div_eff  = (div_q == '0) ? DIV_W'(1) : div_q;

    if (vblank_start) begin
      case (state_q)
        StPlay: begin
          if (tick_q == div_eff - DIV_W'(1)) begin
            advance = 1'b1;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + DIV_W'(1);
          end
        end
        StStep: begin
          advance = 1'b1;
          state_d = StPause;
        end
        default: ;
      endcase
    end

    if (advance) begin
      strobe_d = 1'b1;
      if (!dir_q) idx_d = (idx_q == LastIdx) ? '0 : idx_q + IDX_W'(1);
      else        idx_d = (idx_q == '0) ? LastIdx : idx_q - IDX_W'(1);
    end

    if (cmd_fire) begin
      case (cmd_op)
        OpSetDiv: begin
          div_d  = cmd_arg;
          tick_d = '0;
        end
        OpPlay: begin
          dir_d   = cmd_arg[0];
          tick_d  = '0;
          state_d = StPlay;
        end
        OpPause: state_d = StPause;
        OpStep: begin
          dir_d   = cmd_arg[0];
          state_d = StStep;
        end
        default: ;
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge px_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q  <= StPlay;
      div_q    <= DefDiv;
      dir_q    <= 1'b0;
      tick_q   <= '0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      dir_q    <= dir_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
    end
  end

  assign frame_index  = idx_q;
  assign frame_strobe = strobe_q;
  assign playing      = (state_q == StPlay);

`ifndef SYNTHESIS
  // The renderer ROM only holds NUM_FRAMES frames.
  always @(posedge px_clk) begin
    if (rst_n_int) begin
      assert (idx_q <= LastIdx) else $error("frame_index out of range: %0d", idx_q);
    end
  end
`endif

endmodule

// File: tb/tb_nyancat_frame_sequencer.sv
// Bench for nyancat_frame_sequencer: a reference model pushes each expected new frame index
// into a queue; a monitor pops and compares on every frame_strobe.
module tb_nyancat_frame_sequencer;

  logic       px_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vblank_start = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_arg = 8'd0;
  logic [3:0] frame_index;
  logic       frame_strobe;
  logic       playing;

  nyancat_frame_sequencer dut (
    .px_clk      (px_clk),
    .reset_n     (reset_n),
    .vblank_start(vblank_start),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_arg     (cmd_arg),
    .frame_index (frame_index),
    .frame_strobe(frame_strobe),
    .playing     (playing)
  );

  always #5 px_clk = ~px_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  bit mon_en   = 1'b0;
  bit prev_strobe = 1'b0;

  // Reference model: 0 play, 1 pause, 2 step.
  int m_state, m_div, m_dir, m_tick, m_idx;

  typedef struct {
    logic       do_cmd;
    logic [1:0] op;
    logic [7:0] arg;
    int         nvb;
    int         exp_idx;
    logic       exp_play;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void mdl_reset();
    m_state = 0; m_div = 6; m_dir = 0; m_tick = 0; m_idx = 0;
    exp_q.delete();
  endfunction

  function automatic void mdl_step(input logic vb, input logic cv, input logic [1:0] op,
                                   input logic [7:0] arg);
    int ns = m_state;
    int nt = m_tick;
    bit adv = 0;
    bit acc = cv && (m_state != 2);
    int de = (m_div == 0) ? 1 : m_div;
    if (vb) begin
      if (m_state == 0) begin
        if (m_tick == de - 1) begin adv = 1; nt = 0; end
        else nt = m_tick + 1;
      end else if (m_state == 2) begin
        adv = 1; ns = 1;
      end
    end
    if (adv) begin
      if (m_dir == 0) m_idx = (m_idx == 11) ? 0 : m_idx + 1;
      else            m_idx = (m_idx == 0) ? 11 : m_idx - 1;
      exp_q.push_back(m_idx);
    end
    if (acc) begin
      case (op)
        2'd0: begin m_div = int'(arg); nt = 0; end
        2'd1: begin m_dir = int'(arg[0]); nt = 0; ns = 0; end
        2'd2: ns = 1;
        default: begin m_dir = int'(arg[0]); ns = 2; end
      endcase
    end
    m_state = ns;
    m_tick  = nt;
  endfunction

  // Called at #1 after an edge; returns at #1 after the next edge.
  task automatic drive_cycle(input logic vb, input logic cv, input logic [1:0] op,
                             input logic [7:0] arg);
    vblank_start = vb; cmd_valid = cv; cmd_op = op; cmd_arg = arg;
    @(posedge px_clk);
    mdl_step(vb, cv, op, arg);
    #1;
    vblank_start = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic vblank();
    drive_cycle(1'b1, 1'b0, 2'd0, 8'd0);
    drive_cycle(1'b0, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg);
    drive_cycle(1'b0, 1'b1, op, arg);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge px_clk) begin
    if (mon_en) begin
      if (frame_strobe) begin
        if (prev_strobe) check("strobe_consecutive", 1, 0);
        if (exp_q.size() == 0) check("strobe_unexpected", int'(frame_index), -1);
        else check("strobe_index", int'(frame_index), exp_q.pop_front());
      end
      prev_strobe = frame_strobe;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 2'd0, 8'd1, 11, 0, 1'b1};  // SET_DIV 1, wrap to 0
    vecs[1] = '{1'b1, 2'd1, 8'd1, 1, 11, 1'b1};  // reverse wrap
    vecs[2] = '{1'b1, 2'd1, 8'd1, 2, 9, 1'b1};
    vecs[3] = '{1'b1, 2'd0, 8'd0, 3, 6, 1'b1};   // div 0 acts as 1
    vecs[4] = '{1'b1, 2'd0, 8'd3, 3, 5, 1'b1};
    vecs[5] = '{1'b1, 2'd1, 8'd0, 6, 7, 1'b1};
    vecs[6] = '{1'b1, 2'd2, 8'd0, 20, 7, 1'b0};  // paused: no motion
    vecs[7] = '{1'b1, 2'd0, 8'd2, 4, 7, 1'b0};

    mdl_reset();
    #23 reset_n = 1'b1;
    repeat (3) @(posedge px_clk);
    #1;
    mon_en = 1'b1;

    // Reset state and first advance after six vblanks.
    check("rst_index", int'(frame_index), 0);
    check("rst_strobe", int'(frame_strobe), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_playing", int'(playing), 1);
    repeat (5) vblank();
    check("t1_before_6th", int'(frame_index), 0);
    drive_cycle(1'b1, 1'b0, 2'd0, 8'd0);
    check("t1_latency_index", int'(frame_index), 1);
    check("t1_latency_strobe", int'(frame_strobe), 1);
    drive_cycle(1'b0, 1'b0, 2'd0, 8'd0);
    check("t1_strobe_drop", int'(frame_strobe), 0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_cmd) send_cmd(vecs[i].op, vecs[i].arg);
      for (int j = 0; j < vecs[i].nvb; j++) vblank();
      check($sformatf("vec%0d_index", i), int'(frame_index), vecs[i].exp_idx);
      check($sformatf("vec%0d_playing", i), int'(playing), int'(vecs[i].exp_play));
      check($sformatf("vec%0d_ready", i), int'(cmd_ready), 1);
    end

    // STEP from pause; a command held while not ready must survive.
    send_cmd(2'd3, 8'd0);
    check("step_ready_low", int'(cmd_ready), 0);
    check("step_playing", int'(playing), 0);
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b1, 2'd0, 8'd1);
    check("step_wait_index", int'(frame_index), 7);
    check("step_wait_ready", int'(cmd_ready), 0);
    drive_cycle(1'b1, 1'b1, 2'd0, 8'd1);
    check("step_index", int'(frame_index), 8);
    check("step_ready_back", int'(cmd_ready), 1);
    check("step_paused", int'(playing), 0);
    drive_cycle(1'b0, 1'b1, 2'd0, 8'd1);
    send_cmd(2'd1, 8'd0);
    vblank();
    check("held_cmd_taken", int'(frame_index), 9);

    // PAUSE together with a due vblank: advance, then paused.
    drive_cycle(1'b1, 1'b1, 2'd2, 8'd0);
    check("pause_vb_index", int'(frame_index), 10);
    check("pause_vb_playing", int'(playing), 0);
    drive_cycle(1'b0, 1'b0, 2'd0, 8'd0);

    // STEP together with a vblank while paused: the step waits.
    drive_cycle(1'b1, 1'b1, 2'd3, 8'd0);
    check("step_vb_no_adv", int'(frame_index), 10);
    check("step_vb_ready", int'(cmd_ready), 0);
    drive_cycle(1'b0, 1'b0, 2'd0, 8'd0);
    vblank();
    check("step_vb_next", int'(frame_index), 11);
    check("step_vb_paused", int'(playing), 0);

    // Asynchronous reset while in STEP at frame 7.
    send_cmd(2'd0, 8'd1);
    send_cmd(2'd1, 8'd1);
    repeat (4) vblank();
    send_cmd(2'd3, 8'd0);
    check("pre_rst_index", int'(frame_index), 7);
    check("pre_rst_ready", int'(cmd_ready), 0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_index", int'(frame_index), 0);
    check("async_rst_strobe", int'(frame_strobe), 0);
    check("async_rst_ready", int'(cmd_ready), 1);
    check("async_rst_playing", int'(playing), 1);
    mdl_reset();
    repeat (2) @(posedge px_clk);
    #3 reset_n = 1'b1;
    repeat (3) @(posedge px_clk);
    #1;
    repeat (5) vblank();
    check("post_rst_5", int'(frame_index), 0);
    vblank();
    check("post_rst_6", int'(frame_index), 1);

    repeat (2) @(posedge px_clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
